tree_sum_accumulator: RTL
=========================

// Module: tree_sum_accumulator
// PURPOSE
//  Consumer end of the binary tree adder output. Accepts one reduced tree sum per beat
//  over a valid/ready input and accumulates K beats into one result. Presents that result
//  on a valid/ready output with a sticky overflow flag. Sits between the tree adder and
//  the output writeback, so wide dot products can be split across several tree passes.
// PARAMETERS
//  IN_W   32   width of in_data_i; must be <= ACC_W, otherwise $fatal at elaboration
//  ACC_W  32   accumulator and result width
//  MAX_K  256  largest beat count per group; KW = $clog2(MAX_K+1)
// PORTS
//  clk_i           in   1      clock, all state on rising edge
//  rst_ni          in   1      asynchronous active-low reset
//  clear_i         in   1      synchronous abort of partial group and held result
//  k_i             in   KW     beats per group, sampled on first beat of a group
//  signed_i        in   1      1: sign-extend inputs, signed overflow; 0: zero-extend, carry overflow
//  in_valid_i      in   1      input beat valid
//  in_ready_o      out  1      input beat ready
//  in_data_i       in   IN_W   tree sum
//  out_valid_o     out  1      result valid
//  out_ready_i     in   1      result ready
//  out_data_o      out  ACC_W  accumulated result
//  out_overflow_o  out  1      sticky overflow of this group, qualified by out_valid_o
//  busy_o          out  1      1 when state != IDLE
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=IDLE, acc=0, cnt=0, out_valid_o=0, out_data_o=0,
//   out_overflow_o=0, busy_o=0. in_ready_o is 1 as soon as rst_ni=1 (IDLE).
//  Beat: in_valid_i & in_ready_o. Result transfer: out_valid_o & out_ready_i.
//  ext(x) = signed_q ? sign-extend(x) : zero-extend(x), where signed_q is latched with k.
//  Arithmetic is modulo 2^ACC_W and never saturates.
//  ovf: signed: operand signs are equal and the sum sign differs; unsigned: carry out of ACC_W.
//  FSM:
//   IDLE: in_ready_o=1. On a beat: k_q = (k_i==0) ? 1 : k_i, signed_q=signed_i,
//    acc=ext(in), cnt=1, ovf=0. Go to HOLD if k_q==1, else go to ACCUM.
//   ACCUM: in_ready_o=1. On a beat: acc+=ext(in), cnt++, ovf|=overflow.
//    When cnt reaches k_q, go to HOLD. No beat: hold all state (stalls are allowed anywhere).
//   HOLD: out_valid_o=1. out_data_o=acc and out_overflow_o=ovf, both stable until transfer.
//    in_ready_o = out_ready_i, combinational.
//    Transfer with no beat: go to IDLE.
//    Transfer with a beat in the same cycle: start a new group as IDLE would
//    (new k_i/signed_i sampled). Back-to-back groups therefore lose no cycle.
//  Latency: result is valid the cycle after the last beat is accepted.
//   Throughput is 1 beat/cycle, including across group boundaries.
//  clear_i (highest priority): in_ready_o=0 and no transfer is counted in that cycle.
//   Next state is IDLE with acc=cnt=ovf=0. Any held, untaken result is dropped.
//  k_i and signed_i changing mid-group have no effect.
//  out_valid_o never drops without a transfer, except on clear_i or reset.
//  Reset mid-group or mid-HOLD: everything returns to its reset values immediately.
// TESTING
//  1) k=4, signed=1, beats 5,-3,7,-1 -> out_data=8, ovf=0, out_valid exactly one cycle
//     after the 4th beat.
//  2) k=2, signed=1, ACC_W=32, beats 0x7FFFFFFF,1 -> out_data=0x80000000, ovf=1;
//     next group k=1 beat 2 -> ovf=0.
//  3) k=2, signed=0, IN_W=16, ACC_W=32, beats 0xFFFF,0xFFFF -> out_data=0x0001FFFE
//     (zero-extended), ovf=0; same with signed=1 -> 0xFFFFFFFE.
//  4) out_ready_i=0 for 5 cycles in HOLD while in_valid_i=1 -> data stable, in_ready_o=0;
//     then out_ready_i=1 -> transfer and new-group beat in the same cycle.
//  5) k=0, beat 9 -> treated as k=1, out_data=9. Random valid/ready stalls over 1000 groups
//     must match the reference model.
//  6) clear_i after 2 of 4 beats, then k=1 beat 3 -> out_data=3; rst_ni pulse in HOLD
//     -> out_valid_o=0 asynchronously.

Source files
------------

// File: rtl/tree_sum_accumulator_if.sv
// ----------------------------------------------------------------------------
// tree_sum_accumulator_if
// Bundles the data-path and handshake signals of tree_sum_accumulator.
//   slave  : view used by the accumulator itself
//   master : view used by whoever drives beats and takes results
// Signals:
//   clear_i        synchronous abort of partial group and held result
//   k_i            beats per group, sampled on the first beat of a group
//   signed_i       1: signed arithmetic, 0: unsigned arithmetic
//   in_valid_i / in_ready_o / in_data_i       beat handshake and tree sum
//   out_valid_o / out_ready_i / out_data_o    result handshake and sum
//   out_overflow_o sticky overflow of the presented group
//   busy_o         accumulator is not idle
// ----------------------------------------------------------------------------
interface tree_sum_accumulator_if #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 32,
    parameter int MAX_K = 256
);
    localparam int KW = $clog2(MAX_K + 1);

    logic              clear_i;
    logic [KW-1:0]     k_i;
    logic              signed_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [IN_W-1:0]   in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ACC_W-1:0]  out_data_o;
    logic              out_overflow_o;
    logic              busy_o;

    modport slave (
        input  clear_i, k_i, signed_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_overflow_o, busy_o
    );

    modport master (
        output clear_i, k_i, signed_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_overflow_o, busy_o
    );
endinterface

// File: rtl/tree_sum_accumulator.sv
// ----------------------------------------------------------------------------
// tree_sum_accumulator
// Consumer end of the binary tree adder. Accepts one reduced tree sum per
// beat and accumulates k beats into one result, which is then offered on a
// valid/ready output together with a sticky overflow flag. A result transfer
// and the first beat of the next group may happen in the same cycle, so the
// input sustains one beat per cycle across group boundaries.
// Ports:
//   clk_i   clock, all state on rising edge
//   rst_ni  asynchronous active-low reset
//   bus     tree_sum_accumulator_if.slave (handshakes, data, control, status)
// ----------------------------------------------------------------------------
module tree_sum_accumulator #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 32,
    parameter int MAX_K = 256,
    localparam int KW   = $clog2(MAX_K + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    tree_sum_accumulator_if.slave   bus
);

    // A tree sum wider than the accumulator cannot be represented.
    if (IN_W > ACC_W) begin : g_width_check
        $fatal(1, "tree_sum_accumulator: IN_W must not exceed ACC_W");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};

    // Widen an input beat to accumulator width.
    function automatic logic [ACC_W-1:0] ext_in(input logic [IN_W-1:0] x,
                                                input logic            sgn);
        logic [ACC_W-1:0] r;
        if (sgn) begin
            r = ACC_W'($signed(x));
        end else begin
            r = ACC_W'(x);
        end
        return r;
    endfunction

    // Modulo-2^ACC_W add; MSB of the result is the overflow of this step
    // (signed: operands agree in sign but the sum does not; unsigned: carry).
    function automatic logic [ACC_W:0] add_ovf(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b,
                                               input logic             sgn);
        logic [ACC_W:0] wide;
        logic           ovf;
        wide = {1'b0, a} + {1'b0, b};
        if (sgn) begin
            ovf = (a[ACC_W-1] == b[ACC_W-1]) && (wide[ACC_W-1] != a[ACC_W-1]);
        end else begin
            ovf = wide[ACC_W];
        end
        return {ovf, wide[ACC_W-1:0]};
    endfunction

    state_t           state_r, state_n;
    logic [ACC_W-1:0] acc_r, acc_n;
    logic [KW-1:0]    cnt_r, cnt_n;
    logic [KW-1:0]    k_r, k_n;
    logic             ovf_r, ovf_n;
    logic             sgn_r, sgn_n;

    logic             in_ready_s;
    logic             beat_s;
    logic             xfer_s;
    logic             start_s;
    logic [KW-1:0]    k_eff_s;
    logic [ACC_W:0]   sum_s;

    // Next-state, datapath update and input-ready decode.
    always_comb begin
        state_n    = state_r;
        acc_n      = acc_r;
        cnt_n      = cnt_r;
        k_n        = k_r;
        ovf_n      = ovf_r;
        sgn_n      = sgn_r;
        in_ready_s = 1'b0;

        case (state_r)
            S_IDLE:  in_ready_s = 1'b1;
            S_ACCUM: in_ready_s = 1'b1;
            // Only accept a new beat when the held result leaves this cycle.
            S_HOLD:  in_ready_s = bus.out_ready_i;
            default: in_ready_s = 1'b0;
        endcase

        if (bus.clear_i) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = in_ready_s;
        end

        beat_s  = bus.in_valid_i & in_ready_s;
        xfer_s  = (state_r == S_HOLD) & bus.out_ready_i & ~bus.clear_i;
        start_s = beat_s & ((state_r == S_IDLE) | xfer_s);
        k_eff_s = (bus.k_i == {KW{1'b0}}) ? K_ONE : bus.k_i;
        sum_s   = add_ovf(acc_r, ext_in(bus.in_data_i, sgn_r), sgn_r);

        if (bus.clear_i) begin
            state_n = S_IDLE;
            acc_n   = {ACC_W{1'b0}};
            cnt_n   = {KW{1'b0}};
            ovf_n   = 1'b0;
        end else if (start_s) begin
            k_n     = k_eff_s;
            sgn_n   = bus.signed_i;
            acc_n   = ext_in(bus.in_data_i, bus.signed_i);
            cnt_n   = K_ONE;
            ovf_n   = 1'b0;
            state_n = (k_eff_s == K_ONE) ? S_HOLD : S_ACCUM;
        end else if ((state_r == S_ACCUM) && beat_s) begin
            acc_n   = sum_s[ACC_W-1:0];
            cnt_n   = cnt_r + K_ONE;
            ovf_n   = ovf_r | sum_s[ACC_W];
            state_n = (cnt_n == k_r) ? S_HOLD : S_ACCUM;
        end else if (xfer_s) begin
            state_n = S_IDLE;
        end else begin
            state_n = state_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {KW{1'b0}};
            k_r     <= K_ONE;
            ovf_r   <= 1'b0;
            sgn_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            acc_r   <= acc_n;
            cnt_r   <= cnt_n;
            k_r     <= k_n;
            ovf_r   <= ovf_n;
            sgn_r   <= sgn_n;
        end
    end

    // Result and status come straight from registers; acc/ovf only change
    // on a beat or clear, so they stay stable while a result is held.
    assign bus.out_valid_o    = (state_r == S_HOLD);
    assign bus.out_data_o     = acc_r;
    assign bus.out_overflow_o = ovf_r;
    assign bus.busy_o         = (state_r != S_IDLE);
    assign bus.in_ready_o     = in_ready_s;

endmodule
